// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit, 8-register MIPS pipeline: widths,
// ALU operation classes, R-type funct codes and the pipeline register layouts.
package mips_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [2:0] FUNCT_ADD = 3'b000;
  localparam logic [2:0] FUNCT_SUB = 3'b001;
  localparam logic [2:0] FUNCT_AND = 3'b010;
  localparam logic [2:0] FUNCT_OR  = 3'b011;
  localparam logic [2:0] FUNCT_SLT = 3'b100;

  // ID/EX register contents; an all-zero value is a bubble.
  typedef struct packed {
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic [DATA_W-1:0] immediate;
    logic [DATA_W-1:0] pc_plus1;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic              reg_dst;
    logic              alu_src;
    logic              mem_to_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic [1:0]        alu_op;
  } idex_t;

  // EX/MEM register contents.
  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [DATA_W-1:0] branch_target;
    logic [REG_W-1:0]  write_register;
    logic              zero;
    logic              mem_to_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
  } exmem_t;

  // The ALU is driven with funct-style codes; fixed classes map onto them.
  function automatic logic [2:0] alu_op_sel(input logic [1:0] alu_op,
                                            input logic [2:0] funct);
    case (alu_op)
      ALUOP_ADD: return FUNCT_ADD;
      ALUOP_SUB: return FUNCT_SUB;
      ALUOP_OR:  return FUNCT_OR;
      default:   return funct;
    endcase
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode-side, write-back-side and EX/MEM-side signals of the execute stage.
interface execute_stage_if;
  import mips_pkg::*;

  logic              flush;
  logic [DATA_W-1:0] id_read_data_1;
  logic [DATA_W-1:0] id_read_data_2;
  logic [DATA_W-1:0] id_immediate;
  logic [DATA_W-1:0] id_pc_plus1;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic              id_RegDst;
  logic              id_ALUSrc;
  logic              id_MemtoReg;
  logic              id_RegWrite;
  logic              id_MemRead;
  logic              id_MemWrite;
  logic              id_Branch;
  logic [1:0]        id_ALUOp;
  logic              wb_RegWrite;
  logic [REG_W-1:0]  wb_write_register;
  logic [DATA_W-1:0] wb_write_data;

  logic              stall;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_store_data;
  logic [DATA_W-1:0] ex_branch_target;
  logic [REG_W-1:0]  ex_write_register;
  logic              ex_zero;
  logic              ex_branch_taken;
  logic              ex_MemtoReg;
  logic              ex_RegWrite;
  logic              ex_MemRead;
  logic              ex_MemWrite;
  logic              ex_Branch;

  modport master (
    output flush, id_read_data_1, id_read_data_2, id_immediate, id_pc_plus1,
           id_rs, id_rt, id_rd, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
           id_MemRead, id_MemWrite, id_Branch, id_ALUOp,
           wb_RegWrite, wb_write_register, wb_write_data,
    input  stall, ex_alu_result, ex_store_data, ex_branch_target,
           ex_write_register, ex_zero, ex_branch_taken, ex_MemtoReg,
           ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch
  );

  modport slave (
    input  flush, id_read_data_1, id_read_data_2, id_immediate, id_pc_plus1,
           id_rs, id_rt, id_rd, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
           id_MemRead, id_MemWrite, id_Branch, id_ALUOp,
           wb_RegWrite, wb_write_register, wb_write_data,
    output stall, ex_alu_result, ex_store_data, ex_branch_target,
           ex_write_register, ex_zero, ex_branch_taken, ex_MemtoReg,
           ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch
  );

endinterface

// File: rtl/alu.sv
// Combinational 16-bit ALU; op uses the R-type funct encoding.
module alu
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // Result select; unused codes give 0, slt compares as signed.
  always_comb begin
    result = '0;
    case (op)
      FUNCT_ADD: result = a + b;
      FUNCT_SUB: result = a - b;
      FUNCT_AND: result = a & b;
      FUNCT_OR:  result = a | b;
      FUNCT_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default:   result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ID/EX register, forwarding, load-use stall, ALU, branch
// target and the EX/MEM register feeding the memory stage.
module execute_stage
  import mips_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  execute_stage_if.slave bus
);

  idex_t             idex_q, idex_d;
  exmem_t            exmem_q, exmem_d;
  logic              stall;
  logic [DATA_W-1:0] fwd_a, fwd_b, alu_b, alu_result;
  logic              alu_zero;
  logic [2:0]        alu_op;
  logic [REG_W-1:0]  dest_reg;

  // A load in EX whose target is read by the instruction in decode costs one bubble.
  assign stall = idex_q.mem_read & idex_q.reg_write &
                 ((idex_q.rt == bus.id_rs) | (idex_q.rt == bus.id_rt));

  // ID/EX next value: capture decode, or insert a bubble on stall/flush.
  always_comb begin
    idex_d = '0;
    if (!(bus.flush || stall)) begin
      idex_d.read_data_1 = bus.id_read_data_1;
      idex_d.read_data_2 = bus.id_read_data_2;
      idex_d.immediate   = bus.id_immediate;
      idex_d.pc_plus1    = bus.id_pc_plus1;
      idex_d.rs          = bus.id_rs;
      idex_d.rt          = bus.id_rt;
      idex_d.rd          = bus.id_rd;
      idex_d.reg_dst     = bus.id_RegDst;
      idex_d.alu_src     = bus.id_ALUSrc;
      idex_d.mem_to_reg  = bus.id_MemtoReg;
      idex_d.reg_write   = bus.id_RegWrite;
      idex_d.mem_read    = bus.id_MemRead;
      idex_d.mem_write   = bus.id_MemWrite;
      idex_d.branch      = bus.id_Branch;
      idex_d.alu_op      = bus.id_ALUOp;
    end
  end

  // Operand forwarding (EX/MEM before MEM/WB), ALU input select and destination.
  always_comb begin
    fwd_a = idex_q.read_data_1;
    if (exmem_q.reg_write && exmem_q.write_register == idex_q.rs)
      fwd_a = exmem_q.alu_result;
    else if (bus.wb_RegWrite && bus.wb_write_register == idex_q.rs)
      fwd_a = bus.wb_write_data;

    fwd_b = idex_q.read_data_2;
    if (exmem_q.reg_write && exmem_q.write_register == idex_q.rt)
      fwd_b = exmem_q.alu_result;
    else if (bus.wb_RegWrite && bus.wb_write_register == idex_q.rt)
      fwd_b = bus.wb_write_data;

    alu_b    = idex_q.alu_src ? idex_q.immediate : fwd_b;
    alu_op   = alu_op_sel(idex_q.alu_op, idex_q.immediate[2:0]);
    dest_reg = idex_q.reg_dst ? idex_q.rd : idex_q.rt;
  end

  alu u_alu (
    .a      (fwd_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // EX/MEM next value; a flush kills the instruction leaving EX.
  always_comb begin
    exmem_d                = '0;
    exmem_d.alu_result     = alu_result;
    exmem_d.store_data     = fwd_b;
    exmem_d.branch_target  = idex_q.pc_plus1 + idex_q.immediate;
    exmem_d.write_register = dest_reg;
    exmem_d.zero           = alu_zero;
    if (!bus.flush) begin
      exmem_d.mem_to_reg = idex_q.mem_to_reg;
      exmem_d.reg_write  = idex_q.reg_write;
      exmem_d.mem_read   = idex_q.mem_read;
      exmem_d.mem_write  = idex_q.mem_write;
      exmem_d.branch     = idex_q.branch;
    end
  end

  // Both pipeline registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
    end
  end

  assign bus.stall             = stall;
  assign bus.ex_alu_result     = exmem_q.alu_result;
  assign bus.ex_store_data     = exmem_q.store_data;
  assign bus.ex_branch_target  = exmem_q.branch_target;
  assign bus.ex_write_register = exmem_q.write_register;
  assign bus.ex_zero           = exmem_q.zero;
  assign bus.ex_branch_taken   = exmem_q.branch & exmem_q.zero;
  assign bus.ex_MemtoReg       = exmem_q.mem_to_reg;
  assign bus.ex_RegWrite       = exmem_q.reg_write;
  assign bus.ex_MemRead        = exmem_q.mem_read;
  assign bus.ex_MemWrite       = exmem_q.mem_write;
  assign bus.ex_Branch         = exmem_q.branch;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus a randomized
// run against an instruction-level reference model.
module tb_execute_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  execute_stage_if bus ();

  execute_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        valid;
    logic [15:0] d1, d2, imm, pc1;
    logic [2:0]  rs, rt, rd;
    logic        regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch;
    logic [1:0]  aluop;
  } instr_t;

  typedef struct {
    logic [15:0] alu, store, target;
    logic [2:0]  wreg;
    logic        zero, memtoreg, regwrite, memread, memwrite, branch, known;
  } exp_t;

  instr_t m_idex;
  exp_t   m_ex;

  function automatic instr_t nop_i();
    instr_t i;
    i = '{default: '0};
    i.valid = 1'b1;
    return i;
  endfunction

  function automatic instr_t rtype_i(input logic [2:0] rs, rt, rd,
                                     input logic [15:0] d1, d2,
                                     input logic [2:0] funct);
    instr_t i;
    i = nop_i();
    i.rs = rs; i.rt = rt; i.rd = rd; i.d1 = d1; i.d2 = d2;
    i.imm = {13'd0, funct};
    i.regdst = 1'b1; i.regwrite = 1'b1; i.aluop = 2'b10;
    return i;
  endfunction

  function automatic instr_t lw_i(input logic [2:0] rs, rt,
                                  input logic [15:0] d1, imm);
    instr_t i;
    i = nop_i();
    i.rs = rs; i.rt = rt; i.d1 = d1; i.imm = imm;
    i.alusrc = 1'b1; i.memtoreg = 1'b1; i.regwrite = 1'b1; i.memread = 1'b1;
    i.aluop = 2'b00;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    bus.id_read_data_1 = i.d1;
    bus.id_read_data_2 = i.d2;
    bus.id_immediate   = i.imm;
    bus.id_pc_plus1    = i.pc1;
    bus.id_rs          = i.rs;
    bus.id_rt          = i.rt;
    bus.id_rd          = i.rd;
    bus.id_RegDst      = i.regdst;
    bus.id_ALUSrc      = i.alusrc;
    bus.id_MemtoReg    = i.memtoreg;
    bus.id_RegWrite    = i.regwrite;
    bus.id_MemRead     = i.memread;
    bus.id_MemWrite    = i.memwrite;
    bus.id_Branch      = i.branch;
    bus.id_ALUOp       = i.aluop;
  endtask

  task automatic set_wb(input logic we, input logic [2:0] r, input logic [15:0] d);
    bus.wb_RegWrite       = we;
    bus.wb_write_register = r;
    bus.wb_write_data     = d;
  endtask

  task automatic rand_inputs();
    instr_t i;
    i.valid    = 1'b1;
    i.d1       = 16'($urandom);
    i.d2       = 16'($urandom);
    i.imm      = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($signed(4'($urandom)));
    i.pc1      = 16'($urandom);
    i.rs       = 3'($urandom_range(0, 7));
    i.rt       = 3'($urandom_range(0, 7));
    i.rd       = 3'($urandom_range(0, 7));
    i.regdst   = 1'($urandom_range(0, 1));
    i.alusrc   = 1'($urandom_range(0, 1));
    i.memtoreg = 1'($urandom_range(0, 1));
    i.regwrite = 1'($urandom_range(0, 1));
    i.memread  = ($urandom_range(0, 2) == 0);
    i.memwrite = 1'($urandom_range(0, 1));
    i.branch   = 1'($urandom_range(0, 1));
    i.aluop    = 2'($urandom_range(0, 3));
    drive(i);
    set_wb(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
    bus.flush = ($urandom_range(0, 7) == 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    drive(nop_i());
    set_wb(1'b0, 3'd0, 16'd0);
    bus.flush = 1'b0;
    tick();
    tick();
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_alu(input logic [1:0] aluop, input logic [2:0] funct,
                                          input logic [15:0] a, b);
    if (aluop == 2'b00) return a + b;
    if (aluop == 2'b01) return a - b;
    if (aluop == 2'b11) return a | b;
    case (funct)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] ref_operand(input logic [2:0] r, input logic [15:0] regval);
    if (m_ex.regwrite && m_ex.wreg == r) return m_ex.alu;
    if (bus.wb_RegWrite && bus.wb_write_register == r) return bus.wb_write_data;
    return regval;
  endfunction

  function automatic logic ref_stall();
    return m_idex.valid && m_idex.memread && m_idex.regwrite &&
           (m_idex.rt == bus.id_rs || m_idex.rt == bus.id_rt);
  endfunction

  task automatic model_reset();
    m_idex       = '{default: '0};
    m_ex         = '{default: '0};
    m_ex.known   = 1'b1;
  endtask

  task automatic model_edge();
    exp_t        n;
    logic        st;
    logic [15:0] a, bf, b;
    instr_t      cap;
    st = ref_stall();
    n  = '{default: '0};
    if (m_idex.valid) begin
      a        = ref_operand(m_idex.rs, m_idex.d1);
      bf       = ref_operand(m_idex.rt, m_idex.d2);
      b        = m_idex.alusrc ? m_idex.imm : bf;
      n.alu    = ref_alu(m_idex.aluop, m_idex.imm[2:0], a, b);
      n.store  = bf;
      n.target = m_idex.pc1 + m_idex.imm;
      n.wreg   = m_idex.regdst ? m_idex.rd : m_idex.rt;
      n.zero   = (n.alu == 16'h0000);
      n.known  = 1'b1;
      if (!bus.flush) begin
        n.memtoreg = m_idex.memtoreg;
        n.regwrite = m_idex.regwrite;
        n.memread  = m_idex.memread;
        n.memwrite = m_idex.memwrite;
        n.branch   = m_idex.branch;
      end
    end
    m_ex = n;
    if (bus.flush || st) begin
      m_idex = '{default: '0};
    end else begin
      cap.valid = 1'b1;
      cap.d1 = bus.id_read_data_1; cap.d2 = bus.id_read_data_2;
      cap.imm = bus.id_immediate;  cap.pc1 = bus.id_pc_plus1;
      cap.rs = bus.id_rs; cap.rt = bus.id_rt; cap.rd = bus.id_rd;
      cap.regdst = bus.id_RegDst; cap.alusrc = bus.id_ALUSrc;
      cap.memtoreg = bus.id_MemtoReg; cap.regwrite = bus.id_RegWrite;
      cap.memread = bus.id_MemRead; cap.memwrite = bus.id_MemWrite;
      cap.branch = bus.id_Branch; cap.aluop = bus.id_ALUOp;
      m_idex = cap;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [57:0] all_out;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rand_inputs();
      tick();
      all_out = {bus.ex_alu_result, bus.ex_store_data, bus.ex_branch_target,
                 bus.ex_write_register, bus.ex_zero, bus.ex_branch_taken,
                 bus.ex_MemtoReg, bus.ex_RegWrite, bus.ex_MemRead,
                 bus.ex_MemWrite, bus.ex_Branch};
      total++;
      if (all_out !== 58'd0 || bus.stall !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs got=%h stall=%b exp=0", all_out, bus.stall);
      end
    end
    drive(rtype_i(3'd1, 3'd2, 3'd5, 16'd3, 16'd4, FUNCT_ADD));
    set_wb(1'b0, 3'd0, 16'd0);
    bus.flush = 1'b0;
    rst = 1'b0;
    tick();
    total++;
    if (bus.ex_RegWrite !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_edge RegWrite got=%b exp=0", bus.ex_RegWrite);
    end
    drive(nop_i());
    tick();
    total++;
    if (bus.ex_alu_result !== 16'd7 || bus.ex_RegWrite !== 1'b1 || bus.ex_write_register !== 3'd5) begin
      bad++;
      $display("FAIL reset_second_edge got=%h/%b/%0d exp=0007/1/5",
               bus.ex_alu_result, bus.ex_RegWrite, bus.ex_write_register);
    end
  endtask

  task automatic test_rtype();
    settle();
    drive(rtype_i(3'd1, 3'd2, 3'd3, 16'h7FFF, 16'h0001, FUNCT_ADD));
    tick();
    drive(rtype_i(3'd1, 3'd2, 3'd4, 16'h7FFF, 16'h0001, FUNCT_SLT));
    tick();
    total++;
    if (bus.ex_alu_result !== 16'h8000 || bus.ex_zero !== 1'b0) begin
      bad++;
      $display("FAIL rtype_add got=%h zero=%b exp=8000 zero=0", bus.ex_alu_result, bus.ex_zero);
    end
    drive(nop_i());
    tick();
    total++;
    if (bus.ex_alu_result !== 16'h0000 || bus.ex_zero !== 1'b1) begin
      bad++;
      $display("FAIL rtype_slt got=%h zero=%b exp=0000 zero=1", bus.ex_alu_result, bus.ex_zero);
    end
  endtask

  task automatic test_forwarding();
    settle();
    drive(rtype_i(3'd1, 3'd2, 3'd3, 16'h0008, 16'h0008, FUNCT_ADD));
    tick();
    drive(rtype_i(3'd3, 3'd3, 3'd4, 16'h1234, 16'h5678, FUNCT_SUB));
    tick();
    total++;
    if (bus.ex_alu_result !== 16'h0010) begin
      bad++;
      $display("FAIL fwd_producer got=%h exp=0010", bus.ex_alu_result);
    end
    set_wb(1'b1, 3'd3, 16'h0099);
    drive(nop_i());
    tick();
    total++;
    if (bus.ex_alu_result !== 16'h0000 || bus.ex_zero !== 1'b1 || bus.ex_write_register !== 3'd4) begin
      bad++;
      $display("FAIL fwd_exmem_priority got=%h zero=%b wr=%0d exp=0000 zero=1 wr=4",
               bus.ex_alu_result, bus.ex_zero, bus.ex_write_register);
    end
    set_wb(1'b0, 3'd0, 16'd0);
    drive(rtype_i(3'd5, 3'd5, 3'd6, 16'h0001, 16'h0001, FUNCT_ADD));
    tick();
    set_wb(1'b1, 3'd5, 16'h0100);
    drive(nop_i());
    tick();
    total++;
    if (bus.ex_alu_result !== 16'h0200) begin
      bad++;
      $display("FAIL fwd_memwb got=%h exp=0200", bus.ex_alu_result);
    end
    set_wb(1'b0, 3'd0, 16'd0);
  endtask

  task automatic test_load_use();
    instr_t add_i;
    settle();
    drive(lw_i(3'd1, 3'd2, 16'h0100, 16'h0004));
    tick();
    add_i = rtype_i(3'd2, 3'd1, 3'd5, 16'hDEAD, 16'h0003, FUNCT_ADD);
    drive(add_i);
    #1;
    total++;
    if (bus.stall !== 1'b1) begin
      bad++;
      $display("FAIL loaduse_stall_high got=%b exp=1", bus.stall);
    end
    tick();
    total++;
    if (bus.ex_alu_result !== 16'h0104 || bus.ex_MemRead !== 1'b1 || bus.ex_write_register !== 3'd2) begin
      bad++;
      $display("FAIL loaduse_lw got=%h/%b/%0d exp=0104/1/2",
               bus.ex_alu_result, bus.ex_MemRead, bus.ex_write_register);
    end
    total++;
    if (bus.stall !== 1'b0) begin
      bad++;
      $display("FAIL loaduse_stall_drop got=%b exp=0", bus.stall);
    end
    tick();
    total++;
    if ({bus.ex_MemtoReg, bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_Branch} !== 5'b0) begin
      bad++;
      $display("FAIL loaduse_bubble ctrl got=%b%b%b%b%b exp=00000", bus.ex_MemtoReg,
               bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_Branch);
    end
    set_wb(1'b1, 3'd2, 16'h0042);
    drive(nop_i());
    tick();
    total++;
    if (bus.ex_alu_result !== 16'h0045 || bus.ex_RegWrite !== 1'b1 || bus.ex_write_register !== 3'd5) begin
      bad++;
      $display("FAIL loaduse_consumer got=%h/%b/%0d exp=0045/1/5",
               bus.ex_alu_result, bus.ex_RegWrite, bus.ex_write_register);
    end
    set_wb(1'b0, 3'd0, 16'd0);
  endtask

  task automatic test_branch_flush();
    instr_t beq;
    settle();
    beq = nop_i();
    beq.rs = 3'd1; beq.rt = 3'd2; beq.d1 = 16'h0033; beq.d2 = 16'h0033;
    beq.pc1 = 16'h0005; beq.imm = 16'hFFFE; beq.branch = 1'b1; beq.aluop = 2'b01;
    drive(beq);
    tick();
    drive(rtype_i(3'd1, 3'd2, 3'd3, 16'h0001, 16'h0002, FUNCT_ADD));
    tick();
    total++;
    if (bus.ex_branch_target !== 16'h0003 || bus.ex_branch_taken !== 1'b1 || bus.ex_zero !== 1'b1) begin
      bad++;
      $display("FAIL branch_target got=%h taken=%b zero=%b exp=0003 taken=1 zero=1",
               bus.ex_branch_target, bus.ex_branch_taken, bus.ex_zero);
    end
    bus.flush = 1'b1;
    drive(rtype_i(3'd4, 3'd5, 3'd6, 16'h0001, 16'h0002, FUNCT_OR));
    tick();
    total++;
    if ({bus.ex_MemtoReg, bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_Branch,
         bus.ex_branch_taken} !== 6'b0) begin
      bad++;
      $display("FAIL flush_first ctrl got=%b%b%b%b%b taken=%b exp=0", bus.ex_MemtoReg,
               bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_Branch, bus.ex_branch_taken);
    end
    bus.flush = 1'b0;
    drive(nop_i());
    tick();
    total++;
    if ({bus.ex_MemtoReg, bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_Branch} !== 5'b0) begin
      bad++;
      $display("FAIL flush_second ctrl got=%b%b%b%b%b exp=00000", bus.ex_MemtoReg,
               bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_Branch);
    end
  endtask

  task automatic test_flush_during_stall();
    settle();
    drive(lw_i(3'd1, 3'd2, 16'h0010, 16'h0000));
    tick();
    drive(rtype_i(3'd2, 3'd1, 3'd5, 16'h0001, 16'h0001, FUNCT_ADD));
    bus.flush = 1'b1;
    #1;
    total++;
    if (bus.stall !== 1'b1) begin
      bad++;
      $display("FAIL flushstall_stall got=%b exp=1", bus.stall);
    end
    tick();
    total++;
    if (bus.ex_MemRead !== 1'b0 || bus.ex_RegWrite !== 1'b0) begin
      bad++;
      $display("FAIL flushstall_lw_killed got=%b%b exp=00", bus.ex_MemRead, bus.ex_RegWrite);
    end
    bus.flush = 1'b0;
    drive(rtype_i(3'd3, 3'd4, 3'd6, 16'h0005, 16'h0006, FUNCT_ADD));
    #1;
    total++;
    if (bus.stall !== 1'b0) begin
      bad++;
      $display("FAIL flushstall_no_stall got=%b exp=0", bus.stall);
    end
    tick();
    total++;
    if (bus.ex_RegWrite !== 1'b0 || bus.ex_MemRead !== 1'b0) begin
      bad++;
      $display("FAIL flushstall_bubble got=%b%b exp=00", bus.ex_RegWrite, bus.ex_MemRead);
    end
    drive(nop_i());
    tick();
    total++;
    if (bus.ex_alu_result !== 16'h000B || bus.ex_RegWrite !== 1'b1 || bus.ex_write_register !== 3'd6) begin
      bad++;
      $display("FAIL flushstall_resume got=%h/%b/%0d exp=000B/1/6",
               bus.ex_alu_result, bus.ex_RegWrite, bus.ex_write_register);
    end
  endtask

  task automatic test_random();
    logic [51:0] got_d, exp_d;
    logic [5:0]  got_c, exp_c;
    rst = 1'b1;
    rand_inputs();
    model_reset();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        rand_inputs();
        rst = 1'b1;
        #1;
        total++;
        if ({bus.ex_alu_result, bus.ex_RegWrite, bus.ex_MemWrite, bus.stall} !== 19'd0) begin
          bad++;
          $display("FAIL rand_async_reset got=%h/%b/%b/%b exp=0", bus.ex_alu_result,
                   bus.ex_RegWrite, bus.ex_MemWrite, bus.stall);
        end
        model_reset();
        tick();
        rst = 1'b0;
      end
      rand_inputs();
      #1;
      total++;
      if (bus.stall !== ref_stall()) begin
        bad++;
        $display("FAIL rand_stall cyc=%0d got=%b exp=%b", c, bus.stall, ref_stall());
      end
      model_edge();
      tick();
      got_c = {bus.ex_MemtoReg, bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite,
               bus.ex_Branch, bus.ex_branch_taken};
      exp_c = {m_ex.memtoreg, m_ex.regwrite, m_ex.memread, m_ex.memwrite,
               m_ex.branch, m_ex.branch & m_ex.zero};
      total++;
      if (got_c !== exp_c) begin
        bad++;
        $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", c, got_c, exp_c);
      end
      if (m_ex.known) begin
        got_d = {bus.ex_alu_result, bus.ex_store_data, bus.ex_branch_target,
                 bus.ex_write_register, bus.ex_zero};
        exp_d = {m_ex.alu, m_ex.store, m_ex.target, m_ex.wreg, m_ex.zero};
        total++;
        if (got_d !== exp_d) begin
          bad++;
          $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, got_d, exp_d);
        end
      end
    end
  endtask

  initial begin
    bus.flush = 1'b0;
    drive(nop_i());
    set_wb(1'b0, 3'd0, 16'd0);
    test_reset();
    test_rtype();
    test_forwarding();
    test_load_use();
    test_branch_flush();
    test_flush_during_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
